// File: rtl/rds_msg_arbiter.sv
// Single-port RDS message BRAM arbiter: reader-priority sharing, double-buffered banks swapped at message wrap.
// Optional host readback path: define RDS_ARB_READBACK_EN.
module rds_msg_arbiter #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MSG_LEN = 260
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef RDS_ARB_READBACK_EN
   input  logic              wr_we,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
`endif
   input  logic              commit,
   output logic              commit_busy,
   output logic              active_bank,
   output logic              addr_err,
   output logic [ADDR_W:0]   ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned RAM_AW = ADDR_W + 1;
   localparam logic [RAM_AW-1:0] MSG_END = RAM_AW'(MSG_LEN);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              swap_c;
   logic              rd_bank_c;
   logic              host_acc_c;
   logic              host_rd_c;
   logic              wr_in_range_c;
   logic [RAM_AW-1:0] last_addr;
   logic              rd_pend;

   // Bank-swap FSM: a commit waits in PENDING until the reader wraps to address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      swap_c    = 1'b0;
      case (state)
         S_IDLE: begin
            if (commit) begin
               state_nxt = S_PENDING;
            end
         end
         S_PENDING: begin
            if (rd_req && (rd_addr == '0)) begin
               state_nxt = S_IDLE;
               swap_c    = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign commit_busy = (state == S_PENDING);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_bank <= 1'b0;
      end else if (swap_c) begin
         active_bank <= ~active_bank;
      end
   end

   // The wrapping read already sees the freshly swapped bank.
   assign rd_bank_c     = active_bank ^ swap_c;
   assign wr_ready      = rst_n & ~rd_req & ~commit_busy;
   assign host_acc_c    = wr_valid & wr_ready;
   assign wr_in_range_c = ({1'b0, wr_addr} < MSG_END);

`ifdef RDS_ARB_READBACK_EN
   assign host_rd_c = ~wr_we;
`else
   assign host_rd_c = 1'b0;
`endif

   assign ram_we    = host_acc_c & ~host_rd_c & wr_in_range_c;
   assign ram_wdata = wr_data;

   // Port mux: reader first, then host; otherwise hold the previous address.
   always_comb begin
      ram_addr = last_addr;
      if (rd_req) begin
         ram_addr = {rd_bank_c, rd_addr};
      end else if (host_acc_c) begin
         ram_addr = {~active_bank, wr_addr};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_addr <= '0;
      end else begin
         last_addr <= ram_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err <= 1'b0;
      end else if (host_acc_c && !wr_in_range_c) begin
         addr_err <= 1'b1;
      end
   end

   // Reader return path: address in t, BRAM data in t+1, registered result in t+2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_pend  <= rd_req;
         rd_valid <= rd_pend;
         if (rd_pend) begin
            rd_data <= ram_rdata;
         end
      end
   end

`ifdef RDS_ARB_READBACK_EN
   logic hr_pend;
   logic hr_oor;

   // Host readback return path; out-of-range reads return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_pend     <= 1'b0;
         hr_oor      <= 1'b0;
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         hr_pend     <= host_acc_c & host_rd_c;
         hr_oor      <= ~wr_in_range_c;
         host_rvalid <= hr_pend;
         if (hr_pend) begin
            host_rdata <= hr_oor ? '0 : ram_rdata;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rds_msg_arbiter.sv
// Self-checking bench for rds_msg_arbiter: BRAM model, bank-level reference model, directed and random stimulus.
module tb_rds_msg_arbiter;
   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned MSG_LEN = 260;
   localparam int          BANK_SZ = 512;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_we_tb = 1'b1;
   logic              commit = 1'b0;
   logic              commit_busy;
   logic              active_bank;
   logic              addr_err;
   logic [ADDR_W:0]   ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
`ifdef RDS_ARB_READBACK_EN
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
`endif

   rds_msg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MSG_LEN(MSG_LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef RDS_ARB_READBACK_EN
      .wr_we(wr_we_tb), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
`endif
      .commit(commit), .commit_busy(commit_busy), .active_bank(active_bank), .addr_err(addr_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   logic [7:0] mem    [0:2*BANK_SZ-1];
   logic [7:0] golden [0:2*BANK_SZ-1];

   // Synchronous read-first BRAM, one-cycle latency
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: live bank, pending swap, byte image of both banks, queue of timed read results
   typedef struct { int due; logic [7:0] data; } rd_exp_t;
   rd_exp_t    q[$];
   int         cyc = 0;
   bit         m_bank, m_pend, m_err, m_last_ok;
   logic [7:0] m_rd_data;
   int         m_last;
   bit         exp_rv, swap, rbank, exp_ready, acc, inr;
   int         a;

   always @(negedge clk) begin
      if (run) begin
         cyc++;
         if (!rst_n) begin
            m_bank = 0; m_pend = 0; m_err = 0; m_rd_data = 8'h00;
            m_last = 0; m_last_ok = 1;
            q.delete();
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'd0);
            chk("rst_active_bank", 32'(active_bank), 32'd0);
            chk("rst_commit_busy", 32'(commit_busy), 32'd0);
            chk("rst_addr_err", 32'(addr_err), 32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_wr_ready", 32'(wr_ready), 32'd0);
         end else begin
            exp_rv = (q.size() > 0) && (q[0].due == cyc);
            if (exp_rv) begin
               m_rd_data = q[0].data;
               void'(q.pop_front());
            end
            chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
            chk("active_bank", 32'(active_bank), 32'(m_bank));
            chk("commit_busy", 32'(commit_busy), 32'(m_pend));
            chk("addr_err", 32'(addr_err), 32'(m_err));

            swap      = m_pend && rd_req && (rd_addr == 0);
            rbank     = swap ? !m_bank : m_bank;
            exp_ready = !rd_req && !m_pend;
            acc       = wr_valid && exp_ready;
            inr       = (int'(wr_addr) < int'(MSG_LEN));
            chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
            chk("ram_we", 32'(ram_we), 32'(acc && inr && wr_we_tb));

            if (rd_req) begin
               a = int'(rbank) * BANK_SZ + int'(rd_addr);
               chk("ram_addr_rd", 32'(ram_addr), 32'(a));
               q.push_back('{due: cyc + 2, data: golden[a]});
               m_last = a; m_last_ok = 1;
            end else if (acc && inr) begin
               a = int'(!m_bank) * BANK_SZ + int'(wr_addr);
               chk("ram_addr_wr", 32'(ram_addr), 32'(a));
               if (wr_we_tb) begin
                  chk("ram_wdata", 32'(ram_wdata), 32'(wr_data));
                  golden[a] = wr_data;
               end
               m_last = a; m_last_ok = 1;
            end else if (acc) begin
               m_err = 1;
               m_last_ok = 0;
            end else if (m_last_ok) begin
               chk("ram_addr_hold", 32'(ram_addr), 32'(m_last));
            end

            if (swap) begin
               m_bank = !m_bank;
               m_pend = 0;
            end else if (!m_pend && commit) begin
               m_pend = 1;
            end
         end
      end
   end

   task automatic drive(input bit rq, input int ra, input bit wv, input int wa, input int wd, input bit cm);
      rd_req   = rq;
      rd_addr  = ADDR_W'(ra);
      wr_valid = wv;
      wr_addr  = ADDR_W'(wa);
      wr_data  = DATA_W'(wd);
      commit   = cm;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int k;
   int nwe;
   bit rq, wv, cm;
   int ra, wa, wd;

   initial begin
      for (int i = 0; i < 2*BANK_SZ; i++) begin
         mem[i]    = 8'(i*3 + 1);
         golden[i] = 8'(i*3 + 1);
      end
      run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      drive(0, 0, 1, 0, 0, 0);
      chk("t0_wr_ready_in_reset", 32'(wr_ready), 32'd0);
      chk("t0_active_bank", 32'(active_bank), 32'd0);
      step();
      rst_n = 1'b1;

      // 1: host write to bank 1 does not disturb the live bank 0
      drive(0, 0, 1, 5, 'h41, 0);
      chk("t1_wr_ready", 32'(wr_ready), 32'd1);
      chk("t1_ram_we", 32'(ram_we), 32'd1);
      chk("t1_ram_addr_wr", 32'(ram_addr), 32'h205);
      step();
      drive(1, 5, 0, 0, 0, 0);
      chk("t1_ram_addr_rd", 32'(ram_addr), 32'h005);
      step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_rd_valid", 32'(rd_valid), 32'd1);
      chk("t1_rd_data", 32'(rd_data), 32'h10);
      chk("t1_active_bank", 32'(active_bank), 32'd0);
      step();

      // 2: fill bank 1, commit, swap on the addr-0 read
      for (int i = 0; i < int'(MSG_LEN); i++) begin
         drive(0, 0, 1, i, i ^ 'hA5, 0); step();
      end
      drive(0, 0, 0, 0, 0, 1); step();
      drive(1, 258, 1, 9, 0, 0);
      chk("t2_busy_a", 32'(commit_busy), 32'd1);
      step();
      drive(1, 259, 0, 0, 0, 0); step();
      drive(0, 0, 1, 9, 'h33, 0);
      chk("t2_wr_blocked", 32'(wr_ready), 32'd0);
      chk("t2_busy_b", 32'(commit_busy), 32'd1);
      step();
      drive(1, 0, 0, 0, 0, 0);
      chk("t2_ram_addr_swap", 32'(ram_addr), 32'h200);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_active_bank", 32'(active_bank), 32'd1);
      chk("t2_busy_clr", 32'(commit_busy), 32'd0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_rd_data", 32'(rd_data), 32'hA5);
      step();

      // 3: held write request interleaved with reads; bank 0 is now inactive
      k = 0; nwe = 0;
      for (int i = 0; i < 20; i++) begin
         drive((i % 2) == 0, i*7 + 1, k < 10, 100 + k, 'hC0 + k, 0);
         chk("t3_wr_ready", 32'(wr_ready), 32'(i % 2));
         if (ram_we) nwe++;
         if (wr_valid && wr_ready) k++;
         step();
      end
      chk("t3_write_count", 32'(nwe), 32'd10);
      drive(0, 0, 0, 0, 0, 1); step();
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 10; i++) begin
         drive(1, 100 + i, 0, 0, 0, 0); step();
      end
      drive(1, 103, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t3_readback", 32'(rd_data), 32'hC3);
      step();

      // 4: out-of-range write is accepted but not written; error is sticky
      drive(0, 0, 1, 300, 'h77, 0);
      chk("t4_wr_ready", 32'(wr_ready), 32'd1);
      chk("t4_ram_we", 32'(ram_we), 32'd0);
      step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 1, 4, 'h12, 0);
      chk("t4_addr_err", 32'(addr_err), 32'd1);
      step();
      repeat (3) begin drive(0, 0, 0, 0, 0, 0); step(); end
      chk("t4_addr_err_sticky", 32'(addr_err), 32'd1);

      // commit together with an addr-0 read does not swap; the next wrap does
      drive(1, 0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_no_swap_same_cycle", 32'(active_bank), 32'd0);
      chk("t5_pending", 32'(commit_busy), 32'd1);
      step();
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_swapped", 32'(active_bank), 32'd1);
      step();

      // 5: reset while a commit is pending and a read is in flight
      drive(1, 7, 0, 0, 0, 1); step();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0); step();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_rd_dropped", 32'(rd_valid), 32'd0);
      chk("t5_bank_rst", 32'(active_bank), 32'd0);
      chk("t5_busy_rst", 32'(commit_busy), 32'd0);
      step();
      drive(1, 3, 0, 0, 0, 0);
      chk("t5_ram_addr", 32'(ram_addr), 32'h003);
      step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_rd_data", 32'(rd_data), 32'h0A);
      step();

      // Random traffic checked cycle by cycle against the model
      for (int n = 0; n < 4000; n++) begin
         rq = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) ra = 0;
         else if ($urandom_range(0, 19) == 0) ra = int'($urandom_range(MSG_LEN, 511));
         else ra = int'($urandom_range(0, MSG_LEN - 1));
         wv = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) wa = int'($urandom_range(MSG_LEN, 511));
         else wa = int'($urandom_range(0, MSG_LEN - 1));
         wd = int'($urandom_range(0, 255));
         cm = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         drive(rq, ra, wv, wa, wd, cm);
         step();
      end
      rst_n = 1'b1;
      repeat (4) begin drive(0, 0, 0, 0, 0, 0); step(); end

`ifdef RDS_ARB_READBACK_EN
      // 6: host write then readback of the inactive bank
      drive(0, 0, 1, 7, 'h5A, 0); step();
      wr_we_tb = 1'b0;
      drive(0, 0, 1, 7, 0, 0);
      chk("t6_rd_accept", 32'(wr_ready), 32'd1);
      step();
      wr_we_tb = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_rvalid_early", 32'(host_rvalid), 32'd0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_host_rvalid", 32'(host_rvalid), 32'd1);
      chk("t6_host_rdata", 32'(host_rdata), 32'h5A);
      step();
`endif

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
